// File: rtl/jtag_usr_pkg.sv
// Shared helpers and mode encoding for the JTAG user register bank.
package jtag_usr_pkg;

  typedef enum logic {
    MODE_SINGLE = 1'b0,
    MODE_CHAIN  = 1'b1
  } mode_e;

  // ceil(log2(n)), never below 1 so select/count vectors always keep a bit
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/usr_shift_cell.sv
// One WIDTH-bit user register: serial shift/capture stage plus the committed
// parallel word and its one-cycle update strobe.
module usr_shift_cell #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] DEF_VALUE = '0
) (
  input  logic             TCK,
  input  logic             RST,
  input  logic             capEn_i,
  input  logic [WIDTH-1:0] capVal_i,
  input  logic             shiftEn_i,
  input  logic             serIn_i,
  input  logic             updEn_i,
  input  logic             wrMask_i,
  output logic [WIDTH-1:0] po_o,
  output logic             stb_o,
  output logic             lsb_o
);

  logic [WIDTH-1:0] shiftQ, shiftD;
  logic [WIDTH-1:0] poQ, poD;
  logic             stbQ, stbD;

  // Commit always takes the pre-edge shift contents, even if a shift happens on the same edge
  always_comb begin
    shiftD = shiftQ;
    poD    = poQ;
    stbD   = 1'b0;
    if (capEn_i) begin
      shiftD = capVal_i;
    end else if (shiftEn_i) begin
      shiftD = {serIn_i, shiftQ[WIDTH-1:1]};
    end
    if (updEn_i && !wrMask_i) begin
      poD  = shiftQ;
      stbD = 1'b1;
    end
  end

  always_ff @(posedge TCK or posedge RST) begin
    if (RST) begin
      shiftQ <= DEF_VALUE;
      poQ    <= DEF_VALUE;
      stbQ   <= 1'b0;
    end else begin
      shiftQ <= shiftD;
      poQ    <= poD;
      stbQ   <= stbD;
    end
  end

  assign po_o  = poQ;
  assign stb_o = stbQ;
  assign lsb_o = shiftQ[0];

endmodule

// File: rtl/jtag_usr_reg_bank.sv
// Bank of JTAG user registers, addressed singly or as one daisy chain, with
// read-back capture, shift-length checking and per-register write protect.
module jtag_usr_reg_bank
  import jtag_usr_pkg::*;
#(
  parameter int                     NREG      = 4,
  parameter int                     WIDTH     = 16,
  parameter logic [NREG*WIDTH-1:0]  DEF_VALUE = '0
) (
  input  logic                     TCK,
  input  logic                     RST,
  input  logic                     DRCK_EN,
  input  logic                     SEL,
  input  logic                     FSEL_EN,
  input  logic [clog2(NREG)-1:0]   REG_IDX,
  input  logic                     DSY_CHAIN,
  input  logic                     TDI,
  input  logic                     DSY_IN,
  input  logic                     CAPTURE,
  input  logic                     SHIFT,
  input  logic                     UPDATE,
  input  logic                     RB_SEL,
  input  logic [NREG*WIDTH-1:0]    RB_IN,
  input  logic [NREG-1:0]          WR_MASK,
  output logic [NREG*WIDTH-1:0]    PO,
  output logic [NREG-1:0]          UPD_STB,
  output logic                     LEN_ERR,
  output logic                     TDO,
  output logic                     DSY_OUT
);

  localparam int IDXW = clog2(NREG);
  localparam int CNTW = clog2(NREG * WIDTH + 2);
  localparam logic [CNTW-1:0] EXP_SINGLE = CNTW'(WIDTH);
  localparam logic [CNTW-1:0] EXP_CHAIN  = CNTW'(NREG * WIDTH);

  mode_e            mode;
  logic [NREG-1:0]  target;
  logic [NREG-1:0]  lsbVec;
  logic             anyTarget, capAct, ce, updAct, commit;
  logic [CNTW-1:0]  expLen;
  logic [CNTW-1:0]  cntQ, cntD;
  logic             lenErrQ, lenErrD;

  assign mode = mode_e'(DSY_CHAIN);

  // An index with no matching register leaves the target set empty
  always_comb begin
    target = '0;
    if (mode == MODE_CHAIN) begin
      target = '1;
    end else if (FSEL_EN) begin
      for (int k = 0; k < NREG; k++) begin
        target[k] = (REG_IDX == IDXW'(k));
      end
    end
  end

  assign anyTarget = |target;
  assign capAct    = CAPTURE & SEL;
  assign ce        = SHIFT & SEL & DRCK_EN & anyTarget & ~capAct;
  assign updAct    = UPDATE & SEL & anyTarget & ~capAct;
  assign expLen    = (mode == MODE_CHAIN) ? EXP_CHAIN : EXP_SINGLE;
  assign commit    = updAct & (cntQ == expLen);

  always_comb begin
    cntD    = cntQ;
    lenErrD = lenErrQ;
    if (capAct) begin
      cntD    = '0;
      lenErrD = 1'b0;
    end else if (updAct) begin
      cntD = '0;
      if (cntQ != expLen) lenErrD = 1'b1;
    end else if (ce && (cntQ <= expLen)) begin
      cntD = cntQ + CNTW'(1);
    end
  end

  always_ff @(posedge TCK or posedge RST) begin
    if (RST) begin
      cntQ    <= '0;
      lenErrQ <= 1'b0;
    end else begin
      cntQ    <= cntD;
      lenErrQ <= lenErrD;
    end
  end

  // Chain order: DSY_IN -> register NREG-1 -> ... -> register 0 -> DSY_OUT
  for (genvar k = 0; k < NREG; k++) begin : gCell
    logic             chainIn;
    logic             serIn;
    logic [WIDTH-1:0] capVal;

    if (k == NREG - 1) begin : gHead
      assign chainIn = DSY_IN;
    end else begin : gLink
      assign chainIn = lsbVec[k+1];
    end

    assign serIn  = (mode == MODE_CHAIN) ? chainIn : TDI;
    assign capVal = RB_SEL ? RB_IN[k*WIDTH +: WIDTH] : PO[k*WIDTH +: WIDTH];

    usr_shift_cell #(
      .WIDTH     (WIDTH),
      .DEF_VALUE (DEF_VALUE[k*WIDTH +: WIDTH])
    ) uCell (
      .TCK       (TCK),
      .RST       (RST),
      .capEn_i   (capAct & target[k]),
      .capVal_i  (capVal),
      .shiftEn_i (ce & target[k]),
      .serIn_i   (serIn),
      .updEn_i   (commit & target[k]),
      .wrMask_i  (WR_MASK[k]),
      .po_o      (PO[k*WIDTH +: WIDTH]),
      .stb_o     (UPD_STB[k]),
      .lsb_o     (lsbVec[k])
    );
  end

  assign LEN_ERR = lenErrQ;
  assign TDO     = (mode == MODE_SINGLE) & SEL & (|(lsbVec & target));
  assign DSY_OUT = (mode == MODE_CHAIN) & lsbVec[0];

endmodule

// File: tb/tb_jtag_usr_reg_bank.sv
// Self-checking bench for jtag_usr_reg_bank: table of full scans plus
// hand-written reset, update-during-shift and sticky length-error sequences.
module tb_jtag_usr_reg_bank;

  localparam logic [63:0] DEF = 64'h0000_A5A5_0000_0000;
  localparam logic [63:0] RBV = 64'hCAFE_BEEF_D00D_F00D;

  logic        TCK = 1'b0;
  logic        RST, DRCK_EN, SEL, FSEL_EN, DSY_CHAIN, TDI, DSY_IN;
  logic        CAPTURE, SHIFT, UPDATE, RB_SEL;
  logic [1:0]  REG_IDX;
  logic [63:0] RB_IN;
  logic [3:0]  WR_MASK;
  logic [63:0] PO;
  logic [3:0]  UPD_STB;
  logic        LEN_ERR, TDO, DSY_OUT;

  int checkCount = 0;
  int failCount  = 0;

  typedef struct packed {
    logic        chain;
    logic        fsel;
    logic [1:0]  idx;
    logic        rbSel;
    logic [3:0]  mask;
    int          nbits;
    logic [63:0] data;
    logic [63:0] expOut;
    logic [63:0] expPo;
    logic [3:0]  expStb;
    logic        expLenErr;
  } vec_t;

  vec_t vecs [10];

  jtag_usr_reg_bank #(
    .NREG      (4),
    .WIDTH     (16),
    .DEF_VALUE (DEF)
  ) dut (
    .TCK       (TCK),
    .RST       (RST),
    .DRCK_EN   (DRCK_EN),
    .SEL       (SEL),
    .FSEL_EN   (FSEL_EN),
    .REG_IDX   (REG_IDX),
    .DSY_CHAIN (DSY_CHAIN),
    .TDI       (TDI),
    .DSY_IN    (DSY_IN),
    .CAPTURE   (CAPTURE),
    .SHIFT     (SHIFT),
    .UPDATE    (UPDATE),
    .RB_SEL    (RB_SEL),
    .RB_IN     (RB_IN),
    .WR_MASK   (WR_MASK),
    .PO        (PO),
    .UPD_STB   (UPD_STB),
    .LEN_ERR   (LEN_ERR),
    .TDO       (TDO),
    .DSY_OUT   (DSY_OUT)
  );

  always #5 TCK = ~TCK;

  task automatic tick();
    @(posedge TCK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Capture, shift nbits of data LSB first while collecting serial out, then UPDATE
  task automatic applyStimulus(input logic chain, input logic fsel, input logic [1:0] idx,
                               input logic rbSel, input logic [3:0] mask, input int nbits,
                               input logic [63:0] data, output logic [63:0] outBits);
    outBits   = '0;
    SEL       = 1'b1;
    DRCK_EN   = 1'b1;
    FSEL_EN   = fsel;
    DSY_CHAIN = chain;
    REG_IDX   = idx;
    RB_SEL    = rbSel;
    WR_MASK   = mask;
    CAPTURE   = 1'b1;
    tick();
    CAPTURE = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      SHIFT  = 1'b1;
      TDI    = chain ? 1'b0 : data[i];
      DSY_IN = chain ? data[i] : 1'b0;
      outBits[i] = chain ? DSY_OUT : TDO;
      tick();
    end
    SHIFT  = 1'b0;
    UPDATE = 1'b1;
    tick();
    UPDATE = 1'b0;
  endtask

  initial begin
    logic [63:0] outBits;

    vecs[0] = '{1'b0, 1'b1, 2'd1, 1'b0, 4'b0000, 16, 64'h1234, 64'h0,
                64'h0000_A5A5_1234_0000, 4'b0010, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 2'd2, 1'b0, 4'b0000, 16, 64'hA5A5, 64'hA5A5,
                64'h0000_A5A5_1234_0000, 4'b0100, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 2'd0, 1'b0, 4'b0100, 64, 64'hFFFF_FFFF_FFFF_FFFF,
                64'h0000_A5A5_1234_0000, 64'hFFFF_A5A5_FFFF_FFFF, 4'b1011, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 2'd2, 1'b1, 4'b0000, 16, 64'h0F0F, 64'hBEEF,
                64'hFFFF_0F0F_FFFF_FFFF, 4'b0100, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 2'd0, 1'b0, 4'b0000, 64, 64'h4444_3333_2222_1111,
                64'hFFFF_0F0F_FFFF_FFFF, 64'h4444_3333_2222_1111, 4'b1111, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 2'd0, 1'b0, 4'b0000, 15, 64'h7777, 64'h1111,
                64'h4444_3333_2222_1111, 4'b0000, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 2'd3, 1'b0, 4'b0000, 17, 64'h1_8888, 64'h0_4444,
                64'h4444_3333_2222_1111, 4'b0000, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 2'd0, 1'b1, 4'b0000, 64, 64'h0123_4567_89AB_CDEF, RBV,
                64'h0123_4567_89AB_CDEF, 4'b1111, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 2'd0, 1'b0, 4'b0000, 63, 64'hDEAD_BEEF_0000_1111,
                64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 4'b0000, 1'b1};
    vecs[9] = '{1'b0, 1'b0, 2'd1, 1'b0, 4'b0000, 16, 64'hFFFF, 64'h0,
                64'h0123_4567_89AB_CDEF, 4'b0000, 1'b0};

    RST = 1'b1; DRCK_EN = 1'b0; SEL = 1'b0; FSEL_EN = 1'b0; DSY_CHAIN = 1'b0;
    TDI = 1'b0; DSY_IN = 1'b0; CAPTURE = 1'b0; SHIFT = 1'b0; UPDATE = 1'b0;
    RB_SEL = 1'b0; REG_IDX = 2'd0; RB_IN = RBV; WR_MASK = 4'b0000;
    tick(); tick();
    RST = 1'b0;
    tick();

    checkOutput("reset_po", PO, DEF);
    checkOutput("reset_stb", 64'(UPD_STB), 64'h0);
    checkOutput("reset_lenerr", 64'(LEN_ERR), 64'h0);
    checkOutput("reset_tdo", 64'(TDO), 64'h0);
    checkOutput("reset_dsyout", 64'(DSY_OUT), 64'h0);

    // Reset asserted in the middle of a shift after a commit and a length error
    applyStimulus(1'b0, 1'b1, 2'd1, 1'b0, 4'b0000, 16, 64'hFFFF, outBits);
    checkOutput("h1_po_written", PO, 64'h0000_A5A5_FFFF_0000);
    applyStimulus(1'b0, 1'b1, 2'd1, 1'b0, 4'b0000, 5, 64'h1F, outBits);
    checkOutput("h1_lenerr_set", 64'(LEN_ERR), 64'h1);
    SHIFT = 1'b1; TDI = 1'b1;
    tick(); tick(); tick();
    checkOutput("h1_tdo_before_rst", 64'(TDO), 64'h1);
    #2 RST = 1'b1;
    #1;
    checkOutput("h1_rst_po", PO, DEF);
    checkOutput("h1_rst_stb", 64'(UPD_STB), 64'h0);
    checkOutput("h1_rst_lenerr", 64'(LEN_ERR), 64'h0);
    checkOutput("h1_rst_tdo", 64'(TDO), 64'h0);
    SHIFT = 1'b0; TDI = 1'b0;
    tick();
    RST = 1'b0;
    tick();

    for (int v = 0; v < 10; v++) begin
      applyStimulus(vecs[v].chain, vecs[v].fsel, vecs[v].idx, vecs[v].rbSel,
                    vecs[v].mask, vecs[v].nbits, vecs[v].data, outBits);
      checkOutput($sformatf("v%0d_serial_out", v), outBits, vecs[v].expOut);
      checkOutput($sformatf("v%0d_po", v), PO, vecs[v].expPo);
      checkOutput($sformatf("v%0d_stb", v), 64'(UPD_STB), 64'(vecs[v].expStb));
      checkOutput($sformatf("v%0d_lenerr", v), 64'(LEN_ERR), 64'(vecs[v].expLenErr));
      tick();
      checkOutput($sformatf("v%0d_stb_next", v), 64'(UPD_STB), 64'h0);
    end
    WR_MASK = 4'b0000;

    // UPDATE on the 16th shifting edge: commit sees only 15 counted bits
    FSEL_EN = 1'b1; DSY_CHAIN = 1'b0; REG_IDX = 2'd0; RB_SEL = 1'b0;
    CAPTURE = 1'b1;
    tick();
    CAPTURE = 1'b0;
    for (int i = 0; i < 15; i++) begin
      SHIFT = 1'b1; TDI = ((16'h1357 >> i) & 16'h1) != 0;
      tick();
    end
    TDI = 1'b0; UPDATE = 1'b1;
    tick();
    SHIFT = 1'b0; UPDATE = 1'b0;
    checkOutput("h2a_lenerr", 64'(LEN_ERR), 64'h1);
    checkOutput("h2a_po", PO, 64'h0123_4567_89AB_CDEF);
    checkOutput("h2a_stb", 64'(UPD_STB), 64'h0);
    tick(); tick(); tick();
    checkOutput("h2a_lenerr_sticky", 64'(LEN_ERR), 64'h1);

    // UPDATE on the 17th shifting edge: commit uses the pre-edge 16-bit word
    CAPTURE = 1'b1;
    tick();
    CAPTURE = 1'b0;
    checkOutput("h2b_lenerr_cleared", 64'(LEN_ERR), 64'h0);
    for (int i = 0; i < 16; i++) begin
      SHIFT = 1'b1; TDI = ((16'h1357 >> i) & 16'h1) != 0;
      tick();
    end
    TDI = 1'b1; UPDATE = 1'b1;
    tick();
    SHIFT = 1'b0; UPDATE = 1'b0;
    checkOutput("h2b_po", PO, 64'h0123_4567_89AB_1357);
    checkOutput("h2b_stb", 64'(UPD_STB), 64'h1);
    checkOutput("h2b_lenerr", 64'(LEN_ERR), 64'h0);
    checkOutput("h2b_tdo_shifted", 64'(TDO), 64'h1);
    tick();
    checkOutput("h2b_stb_next", 64'(UPD_STB), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/jtag_usr_reg_bank.md
# jtag_usr_reg_bank

Bank of NREG JTAG user registers, WIDTH bits each, loaded from the JTAG user-DR path in the TCK domain.
- Each register is either addressed singly by index, or all registers are concatenated into one daisy chain with a common update.
- Adds three behaviours: capture/read-back, shift-length checking before commit, and per-register write protect with update strobes.
- Sits behind the BSCAN user-instruction decode; feeds configuration PO words to DCFEB fabric logic.

## Interface
- NREG, 4, number of registers (≥1)
- WIDTH, 16, bits per register (≥2)
- DEF_VALUE, all zeros, NREG*WIDTH reset value; register k occupies bits [k*WIDTH +: WIDTH]
- TCK  in  1  JTAG clock; all state changes on posedge
- RST  in  1  reset, asynchronous, active-high
- DRCK_EN  in  1  data-register clock enable
- SEL  in  1  user instruction active
- FSEL_EN  in  1  bank function selected (single mode)
- REG_IDX  in  clog2(NREG) (min 1)  target register in single mode
- DSY_CHAIN  in  1  1 = chain mode, 0 = single mode
- TDI  in  1  serial in, single mode
- DSY_IN  in  1  serial in, chain mode
- CAPTURE, SHIFT, UPDATE  in  1 each  TAP state indicators, one TCK cycle each
- RB_SEL  in  1  capture source: 0 = own PO, 1 = RB_IN
- RB_IN  in  NREG*WIDTH  external read-back words
- WR_MASK  in  NREG  1 = register k write-protected
- PO  out  NREG*WIDTH  parallel outputs; reset DEF_VALUE
- UPD_STB  out  NREG  one-cycle commit strobe per register; reset 0
- LEN_ERR  out  1  sticky shift-length error; reset 0
- TDO  out  1  serial out, single mode; 0 when inactive
- DSY_OUT  out  1  serial out, chain mode; 0 when DSY_CHAIN=0

## Operation
- Target set:
  - Single mode: register REG_IDX, only when FSEL_EN=1 and REG_IDX<NREG; otherwise empty (TDO=0, no shift, no commit).
  - Chain mode: all registers.
- ce = SHIFT & SEL & DRCK_EN & (target set non-empty).
- Single-mode shift: d[idx] <= {TDI, d[idx][WIDTH-1:1]}; TDO = d[idx][0].
- Chain-mode shift:
  - DSY_IN enters MSB of register NREG-1.
  - LSB of register k feeds MSB of register k-1.
  - DSY_OUT = d[0][0]; TDI ignored; TDO = 0.
- Capture: CAPTURE & SEL loads each target d from PO (RB_SEL=0) or RB_IN slice (RB_SEL=1); clears bit counter cnt and LEN_ERR.
- Counter: cnt increments on ce and saturates at EXP+1.
  - EXP = WIDTH in single mode; NREG*WIDTH in chain mode.
- Update: UPDATE & SEL with a non-empty target set.
  - cnt==EXP: each target k with WR_MASK[k]=0 gets PO[k] <= d[k] and UPD_STB[k]=1 for exactly the next cycle.
  - cnt==EXP, masked targets: PO unchanged, no strobe.
  - cnt!=EXP: no PO change, no strobe, LEN_ERR <= 1.
  - cnt cleared to 0 after every update.
- Same-cycle priority: RST > CAPTURE > shift > UPDATE.
  - UPDATE together with ce: the shift occurs; the commit uses pre-edge d and cnt.
- d contents outside the target set never change.
- RST (any time, including mid-shift): d and PO <= DEF_VALUE; cnt, LEN_ERR, UPD_STB <= 0.

## Timing
- PO and UPD_STB change on the UPDATE TCK edge: valid 1 cycle after UPDATE is sampled.
- TDO and DSY_OUT are combinational from d (plus select/mode); new bit visible after each shifting edge.
- Changing DSY_CHAIN or REG_IDX mid-scan is unsupported: cnt check flags it as LEN_ERR if lengths disagree.

## Structure
- Package jtag_usr_pkg: clog2 function and mode constants (MODE_SINGLE=0, MODE_CHAIN=1).
- Sub-module usr_shift_cell: one WIDTH-bit slice with shift, capture, and masked update plus strobe; instantiated NREG times.
- Top level holds target decode, serial muxing, the counter, and LEN_ERR.

## Test plan
Bench parameters: NREG=4, WIDTH=16, DEF_VALUE reg2=16'hA5A5, others 0.
- Reset: assert RST mid-shift -> PO = {0, A5A5, 0, 0}, UPD_STB=0, LEN_ERR=0, TDO=0.
- Single write: REG_IDX=1, capture, shift 16 bits of 16'h1234 LSB first, UPDATE -> PO[1]=1234; UPD_STB=4'b0010 for one cycle; other PO unchanged.
- Read-back: REG_IDX=2, RB_SEL=0, capture, shift 16 bits -> TDO sequence equals A5A5 LSB first; with RB_SEL=1 and RB_IN[2]=16'hBEEF -> TDO returns BEEF.
- Chain write: DSY_CHAIN=1, shift 64 bits of 64'h4444_3333_2222_1111, UPDATE -> PO[k]=kkkk pattern, UPD_STB=4'b1111; DSY_OUT yields the captured data.
- Length error: single mode, shift 15 bits, UPDATE -> PO unchanged, LEN_ERR=1 until next CAPTURE; 17 bits likewise.
- Write protect: WR_MASK=4'b0100, chain write of all 16'hFFFF -> PO[2] stays A5A5; UPD_STB=4'b1011.
